// File: rtl/gravador_sequencia_pkg.sv
// Shared types and width helpers for the note sequence recorder.
// States, the rest code and width functions live here.
package gravador_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        GRAVANDO = 2'd1,
        BUSCA    = 2'd2,
        REPRODUZ = 2'd3
    } estado_t;

    localparam int NOTA_PAUSA = 0;

    function automatic int largura_nota(input int teclas);
        return $clog2(teclas + 1);
    endfunction

    function automatic int largura_end(input int prof);
        return $clog2(prof);
    endfunction

endpackage

// File: rtl/gravador_sequencia_if.sv
// Bundles for the recorder: the key/command/status bus and the
// internal event-memory port.
interface gravador_sequencia_if #(
    parameter int NUM_TECLAS = 13,
    parameter int NW         = 4,
    parameter int CW         = 9
);
    logic [NUM_TECLAS-1:0] teclas;
    logic                  tick;
    logic                  grava;
    logic                  toca;
    logic                  para;
    logic [NW-1:0]         nota_out;
    logic                  nota_valida;
    logic [1:0]            estado;
    logic [CW-1:0]         num_eventos;
    logic                  cheio;
    logic                  saturou;
    logic                  fim_reproducao;

    modport master (
        output teclas, tick, grava, toca, para,
        input  nota_out, nota_valida, estado, num_eventos,
        input  cheio, saturou, fim_reproducao
    );

    modport slave (
        input  teclas, tick, grava, toca, para,
        output nota_out, nota_valida, estado, num_eventos,
        output cheio, saturou, fim_reproducao
    );
endinterface

interface ram_eventos_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    modport master (
        output we, waddr, wdata, raddr,
        input  rdata
    );

    modport slave (
        input  we, waddr, wdata, raddr,
        output rdata
    );
endinterface

// File: rtl/gravador_sequencia_ram.sv
// Event store: one write port, registered read, no reset so that
// recorded contents survive a reset.
module ram_eventos_sync #(
    parameter int PROFUNDIDADE = 256,
    parameter int LARGURA      = 8
) (
    input logic            clock,
    ram_eventos_if.slave   bus
);
    logic [LARGURA-1:0] mem [PROFUNDIDADE];

    always_ff @(posedge clock) begin
        if (bus.we)
            mem[bus.waddr] <= bus.wdata;
        bus.rdata <= mem[bus.raddr];
    end
endmodule

// File: rtl/gravador_sequencia.sv
// Piano key sequence recorder/player, events stored as {code, ticks}.
// Define GRAVADOR_SEQUENCIA_LOOP_EN to loop playback until para.
module gravador_sequencia
    import gravador_pkg::*;
#(
    parameter  int NUM_TECLAS    = 13,
    parameter  int PROFUNDIDADE  = 256,
    parameter  int LARGURA_TEMPO = 4,
    localparam int NW = largura_nota(NUM_TECLAS),
    localparam int AW = largura_end(PROFUNDIDADE),
    localparam int CW = AW + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_TECLAS-1:0] teclas,
    input  logic                  tick,
    input  logic                  grava,
    input  logic                  toca,
    input  logic                  para,
    output logic [NW-1:0]         nota_out,
    output logic                  nota_valida,
    output logic [1:0]            estado,
    output logic [CW-1:0]         num_eventos,
    output logic                  cheio,
    output logic                  saturou,
    output logic                  fim_reproducao
);
    localparam int LT = LARGURA_TEMPO;
    localparam int DW = NW + LT;

    localparam logic [LT-1:0] DUR_MAX  = '1;
    localparam logic [LT-1:0] DUR_ZERO = '0;
    localparam logic [LT-1:0] DUR_UM   = LT'(1);
    localparam logic [CW-1:0] NUM_UM   = CW'(1);
    localparam logic [CW-1:0] NUM_ZERO = '0;
    localparam logic [CW-1:0] NUM_CHEIO = CW'(PROFUNDIDADE);
    localparam logic [NW-1:0] PAUSA    = NW'(NOTA_PAUSA);

    estado_t       estado_q, estado_d;
    logic [NW-1:0] nota_q, nota_d;
    logic [LT-1:0] dur_q, dur_d;
    logic [LT-1:0] cnt_q, cnt_d;
    logic [AW-1:0] end_q, end_d;
    logic [CW-1:0] num_q, num_d;
    logic          cheio_q, cheio_d;
    logic          sat_q, sat_d;
    logic          fim_q, fim_d;

    logic [NW-1:0] codigo;
    logic [LT-1:0] dur_ef;
    logic [LT-1:0] cnt_inc;
    logic [CW-1:0] num_inc;
    logic [CW-1:0] end_inc;
    logic [NW-1:0] nota_lida;
    logic [LT-1:0] dur_lida;

    ram_eventos_if #(.AW(AW), .DW(DW)) ram_bus ();

    ram_eventos_sync #(
        .PROFUNDIDADE (PROFUNDIDADE),
        .LARGURA      (DW)
    ) u_ram (
        .clock (clock),
        .bus   (ram_bus.slave)
    );

    // Lowest asserted key wins.
    always_comb begin
        codigo = PAUSA;
        for (int i = NUM_TECLAS - 1; i >= 0; i--)
            if (teclas[i])
                codigo = NW'(i + 1);
    end

    always_comb begin
        dur_ef = dur_q;
        if (tick && dur_q != DUR_MAX)
            dur_ef = dur_q + DUR_UM;
    end

    assign cnt_inc   = cnt_q + DUR_UM;
    assign num_inc   = num_q + NUM_UM;
    assign end_inc   = {1'b0, end_q} + NUM_UM;
    assign nota_lida = ram_bus.rdata[DW-1:LT];
    assign dur_lida  = ram_bus.rdata[LT-1:0];

    assign ram_bus.raddr = end_q;
    assign ram_bus.waddr = num_q[AW-1:0];
    assign ram_bus.wdata = {nota_q, dur_ef};

    always_comb begin
        estado_d   = estado_q;
        nota_d     = nota_q;
        dur_d      = dur_q;
        cnt_d      = cnt_q;
        end_d      = end_q;
        num_d      = num_q;
        cheio_d    = cheio_q;
        sat_d      = sat_q;
        fim_d      = 1'b0;
        ram_bus.we = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                if (para) begin
                    estado_d = OCIOSO;
                end else if (grava) begin
                    estado_d = GRAVANDO;
                    num_d    = NUM_ZERO;
                    cheio_d  = 1'b0;
                    sat_d    = 1'b0;
                    nota_d   = codigo;
                    dur_d    = DUR_ZERO;
                end else if (toca) begin
                    if (num_q == NUM_ZERO) begin
                        fim_d = 1'b1;
                    end else begin
                        estado_d = BUSCA;
                        end_d    = '0;
                    end
                end
            end
            GRAVANDO: begin
                if (tick && dur_q == DUR_MAX)
                    sat_d = 1'b1;
                if (para) begin
                    if (dur_ef != DUR_ZERO && !cheio_q) begin
                        ram_bus.we = 1'b1;
                        num_d      = num_inc;
                        cheio_d    = (num_inc == NUM_CHEIO);
                    end
                    estado_d = OCIOSO;
                end else if (codigo != nota_q) begin
                    // A zero-length event is simply replaced.
                    if (dur_ef != DUR_ZERO) begin
                        ram_bus.we = 1'b1;
                        num_d      = num_inc;
                        if (num_inc == NUM_CHEIO) begin
                            cheio_d  = 1'b1;
                            estado_d = OCIOSO;
                        end
                    end
                    nota_d = codigo;
                    dur_d  = DUR_ZERO;
                end else begin
                    dur_d = dur_ef;
                end
            end
            BUSCA: begin
                if (para) begin
                    estado_d = OCIOSO;
                end else begin
                    estado_d = REPRODUZ;
                    cnt_d    = DUR_ZERO;
                end
            end
            REPRODUZ: begin
                if (para) begin
                    estado_d = OCIOSO;
                end else if (tick) begin
                    if (cnt_inc == dur_lida) begin
                        estado_d = BUSCA;
                        if (end_inc == num_q) begin
`ifdef GRAVADOR_SEQUENCIA_LOOP_EN
                            end_d = '0;
`else
                            estado_d = OCIOSO;
                            fim_d    = 1'b1;
`endif
                        end else begin
                            end_d = end_inc[AW-1:0];
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            nota_q   <= PAUSA;
            dur_q    <= DUR_ZERO;
            cnt_q    <= DUR_ZERO;
            end_q    <= '0;
            num_q    <= NUM_ZERO;
            cheio_q  <= 1'b0;
            sat_q    <= 1'b0;
            fim_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            nota_q   <= nota_d;
            dur_q    <= dur_d;
            cnt_q    <= cnt_d;
            end_q    <= end_d;
            num_q    <= num_d;
            cheio_q  <= cheio_d;
            sat_q    <= sat_d;
            fim_q    <= fim_d;
        end
    end

    assign estado         = estado_q;
    assign nota_valida    = (estado_q == REPRODUZ);
    assign nota_out       = nota_valida ? nota_lida : PAUSA;
    assign num_eventos    = num_q;
    assign cheio          = cheio_q;
    assign saturou        = sat_q;
    assign fim_reproducao = fim_q;
endmodule

// File: tb/tb_gravador_sequencia.sv
// Directed bench for gravador_sequencia (depth 8, 4-bit durations).
// Build with GRAVADOR_SEQUENCIA_LOOP_EN to check looping playback.
module tb_gravador_sequencia;
    import gravador_pkg::*;

    localparam int NT   = 13;
    localparam int PROF = 8;
    localparam int LT   = 4;
    localparam int NW   = 4;
    localparam int CW   = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    gravador_sequencia_if #(.NUM_TECLAS(NT), .NW(NW), .CW(CW)) bus ();

    gravador_sequencia #(
        .NUM_TECLAS    (NT),
        .PROFUNDIDADE  (PROF),
        .LARGURA_TEMPO (LT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .teclas         (bus.teclas),
        .tick           (bus.tick),
        .grava          (bus.grava),
        .toca           (bus.toca),
        .para           (bus.para),
        .nota_out       (bus.nota_out),
        .nota_valida    (bus.nota_valida),
        .estado         (bus.estado),
        .num_eventos    (bus.num_eventos),
        .cheio          (bus.cheio),
        .saturou        (bus.saturou),
        .fim_reproducao (bus.fim_reproducao)
    );

    typedef struct {
        logic [NT-1:0] teclas;
        logic          tick;
        logic          grava;
        logic          toca;
        logic          para;
        logic [1:0]    estado;
        logic [NW-1:0] nota;
        logic          valida;
        logic [CW-1:0] num;
        logic          fim;
    } vec_t;

    localparam logic [NT-1:0] K2K7  = 13'd132;
    localparam logic [NT-1:0] K5K12 = 13'd4128;

    vec_t grav [9];
    vec_t play [9];

    int checks = 0;
    int fails  = 0;
    int fim_cnt = 0;

    always @(posedge clock)
        if (bus.fim_reproducao)
            fim_cnt++;

    task automatic check(input string nome, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nome, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input logic tk, input logic g,
                       input logic t, input logic p);
        bus.tick  = tk;
        bus.grava = g;
        bus.toca  = t;
        bus.para  = p;
        step();
        bus.tick  = 1'b0;
        bus.grava = 1'b0;
        bus.toca  = 1'b0;
        bus.para  = 1'b0;
    endtask

    task automatic run_row(input string tag, input int i, input vec_t v);
        bus.teclas = v.teclas;
        cyc(v.tick, v.grava, v.toca, v.para);
        check($sformatf("%s[%0d].estado", tag, i), 32'(bus.estado), 32'(v.estado));
        check($sformatf("%s[%0d].nota", tag, i), 32'(bus.nota_out), 32'(v.nota));
        check($sformatf("%s[%0d].valida", tag, i), 32'(bus.nota_valida), 32'(v.valida));
        check($sformatf("%s[%0d].num", tag, i), 32'(bus.num_eventos), 32'(v.num));
        check($sformatf("%s[%0d].fim", tag, i), 32'(bus.fim_reproducao), 32'(v.fim));
    endtask

    initial begin
        // teclas, tick, grava, toca, para | estado, nota, valida, num, fim
        grav[0] = '{13'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'd0, 1'b0, 4'd0, 1'b0};
        grav[1] = '{K2K7,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0, 1'b0, 4'd0, 1'b0};
        grav[2] = '{K2K7,  1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0, 1'b0, 4'd0, 1'b0};
        grav[3] = '{K2K7,  1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0, 1'b0, 4'd0, 1'b0};
        grav[4] = '{K2K7,  1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0, 1'b0, 4'd0, 1'b0};
        grav[5] = '{K5K12, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0, 1'b0, 4'd1, 1'b0};
        grav[6] = '{K5K12, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0, 1'b0, 4'd1, 1'b0};
        grav[7] = '{K5K12, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0, 1'b0, 4'd1, 1'b0};
        grav[8] = '{K5K12, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 4'd2, 1'b0};

        play[0] = '{13'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 4'd2, 1'b0};
        play[1] = '{13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd3, 1'b1, 4'd2, 1'b0};
        play[2] = '{13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'd3, 1'b1, 4'd2, 1'b0};
        play[3] = '{13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'd3, 1'b1, 4'd2, 1'b0};
        play[4] = '{13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0, 1'b0, 4'd2, 1'b0};
        play[5] = '{13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd6, 1'b1, 4'd2, 1'b0};
        play[6] = '{13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'd6, 1'b1, 4'd2, 1'b0};
        play[7] = '{13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 4'd2, 1'b1};
        play[8] = '{13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 4'd2, 1'b0};

        bus.teclas = '0;
        bus.tick   = 1'b0;
        bus.grava  = 1'b0;
        bus.toca   = 1'b0;
        bus.para   = 1'b0;
        repeat (3) step();
        check("rst.estado", 32'(bus.estado), 32'd0);
        check("rst.valida", 32'(bus.nota_valida), 32'd0);
        check("rst.nota", 32'(bus.nota_out), 32'd0);
        check("rst.num", 32'(bus.num_eventos), 32'd0);
        check("rst.cheio", 32'(bus.cheio), 32'd0);
        check("rst.sat", 32'(bus.saturou), 32'd0);
        check("rst.fim", 32'(bus.fim_reproducao), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();

        for (int i = 0; i < 9; i++)
            run_row("grav", i, grav[i]);
        check("mem0", 32'(dut.u_ram.mem[0]), 32'h33);
        check("mem1", 32'(dut.u_ram.mem[1]), 32'h62);
        check("grav.sat", 32'(bus.saturou), 32'd0);
        check("grav.cheio", 32'(bus.cheio), 32'd0);

`ifdef GRAVADOR_SEQUENCIA_LOOP_EN
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("loop.busca0", 32'(bus.estado), 32'd2);
        for (int r = 0; r < 3; r++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("loop%0d.n3", r), 32'(bus.nota_out), 32'd3);
            for (int t = 0; t < 2; t++) begin
                cyc(1'b1, 1'b0, 1'b0, 1'b0);
                check($sformatf("loop%0d.h3", r), 32'(bus.nota_out), 32'd3);
            end
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("loop%0d.gap", r), 32'(bus.estado), 32'd2);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("loop%0d.n6", r), 32'(bus.nota_out), 32'd6);
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("loop%0d.h6", r), 32'(bus.nota_out), 32'd6);
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("loop%0d.wrap", r), 32'(bus.estado), 32'd2);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("loop.para", 32'(bus.estado), 32'd0);
        check("loop.nofim", 32'(fim_cnt), 32'd0);
`else
        for (int i = 0; i < 9; i++)
            run_row("play", i, play[i]);
        check("play.fimcnt", 32'(fim_cnt), 32'd1);
`endif

        // Saturation: one key held for 20 ticks.
        bus.teclas = 13'd1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (15) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat.at15", 32'(bus.saturou), 32'd0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat.at20", 32'(bus.saturou), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat.num", 32'(bus.num_eventos), 32'd1);
        check("sat.estado", 32'(bus.estado), 32'd0);
        check("sat.mem0", 32'(dut.u_ram.mem[0]), 32'h1F);

        // Fill: 9 alternating one-tick notes into 8 slots.
        bus.teclas = 13'd2;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("full.sat_clr", 32'(bus.saturou), 32'd0);
        check("full.num0", 32'(bus.num_eventos), 32'd0);
        for (int k = 0; k < 9; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (k < 8) begin
                bus.teclas = (k % 2 == 0) ? 13'd8 : 13'd2;
                cyc(1'b0, 1'b0, 1'b0, 1'b0);
                check($sformatf("full.num%0d", k + 1),
                      32'(bus.num_eventos), 32'(k + 1));
                check($sformatf("full.cheio%0d", k + 1),
                      32'(bus.cheio), (k == 7) ? 32'd1 : 32'd0);
                check($sformatf("full.est%0d", k + 1),
                      32'(bus.estado), (k == 7) ? 32'd0 : 32'd1);
            end
        end
        check("full.num_end", 32'(bus.num_eventos), 32'd8);
        check("full.est_end", 32'(bus.estado), 32'd0);
        check("full.mem7", 32'(dut.u_ram.mem[7]), 32'h41);
        bus.teclas = '0;

        // para during playback: no end pulse.
        fim_cnt = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("stop.play", 32'(bus.estado), 32'd3);
        check("stop.nota", 32'(bus.nota_out), 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("stop.estado", 32'(bus.estado), 32'd0);
        step();
        check("stop.nofim", 32'(fim_cnt), 32'd0);

        // Asynchronous reset in the middle of playback.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("mid.valida_pre", 32'(bus.nota_valida), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid.estado", 32'(bus.estado), 32'd0);
        check("mid.nota", 32'(bus.nota_out), 32'd0);
        check("mid.valida", 32'(bus.nota_valida), 32'd0);
        check("mid.num", 32'(bus.num_eventos), 32'd0);
        check("mid.cheio", 32'(bus.cheio), 32'd0);
        check("mid.fim", 32'(bus.fim_reproducao), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();

        // toca with nothing stored.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("empty.fim", 32'(bus.fim_reproducao), 32'd1);
        check("empty.estado", 32'(bus.estado), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("empty.fim_off", 32'(bus.fim_reproducao), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule

// File: doc/gravador_sequencia.md
GRAVADOR_SEQUENCIA -- requirements
Module: gravador_sequencia

Interface
REQ-001 The block SHALL have parameter NUM_TECLAS, default 13: number of piano keys sampled.
REQ-002 The block SHALL have parameter PROFUNDIDADE, default 256: event memory depth, power of two.
REQ-003 The block SHALL have parameter LARGURA_TEMPO, default 4: event duration width in metronome ticks.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clock, input, 1 bit: system clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port teclas, input, NUM_TECLAS bits: debounced key levels.
REQ-008 The block SHALL have port tick, input, 1 bit: one-cycle metronome pulse.
REQ-009 The block SHALL have ports grava, toca and para, inputs, 1 bit each: one-cycle command pulses.
REQ-010 The block SHALL have port nota_out, output, NW=$clog2(NUM_TECLAS+1) bits: played note code, 0 = rest.
REQ-011 The block SHALL have port nota_valida, output, 1 bit: nota_out holds a played event.
REQ-012 The block SHALL have port estado, output, 2 bits: FSM state code.
REQ-013 The block SHALL have port num_eventos, output, $clog2(PROFUNDIDADE)+1 bits: stored event count.
REQ-014 The block SHALL have ports cheio and saturou, outputs, 1 bit each: memory full; a duration clipped.
REQ-015 The block SHALL have port fim_reproducao, output, 1 bit: one-cycle pulse at end of playback.

Function
REQ-016 Key encoding SHALL be: lowest-index asserted key i gives code i+1; no key gives 0.
REQ-017 The FSM SHALL have states OCIOSO=0, GRAVANDO=1, BUSCA=2 and REPRODUZ=3, driven on estado.
REQ-018 Command priority SHALL be para > grava > toca; grava and toca SHALL be ignored outside OCIOSO.
REQ-019 grava in OCIOSO SHALL go to GRAVANDO, clear num_eventos, cheio and saturou, latch the current code and zero the duration counter.
REQ-020 In GRAVANDO each tick SHALL increment the duration, saturating at 2^LARGURA_TEMPO-1; a tick at saturation SHALL set saturou.
REQ-021 On a code change, {old code, duration} SHALL be written at address num_eventos if duration>0, then num_eventos increments and the duration restarts at 0 with the new code.
REQ-022 A code change with duration 0 SHALL replace the latched code without writing.
REQ-023 A tick coincident with a code change SHALL count toward the old event.
REQ-024 A write that makes num_eventos equal PROFUNDIDADE SHALL set cheio and return the FSM to OCIOSO.
REQ-025 para in GRAVANDO SHALL flush a pending event with duration>0 (when not full), then go to OCIOSO.
REQ-026 toca with num_eventos=0 SHALL pulse fim_reproducao in the next cycle and stay in OCIOSO.
REQ-027 Otherwise toca SHALL go to BUSCA with read address 0.
REQ-028 BUSCA SHALL last one cycle (synchronous read latency) with nota_valida=0.
REQ-029 REPRODUZ SHALL drive nota_out with the stored code and nota_valida=1 until the stored duration ticks have been counted.
REQ-030 After the last REPRODUZ tick, the FSM SHALL go to BUSCA with the next address.
REQ-031 After the last event, fim_reproducao SHALL pulse and the FSM SHALL go to OCIOSO.
REQ-032 para in BUSCA or REPRODUZ SHALL go to OCIOSO next cycle without pulsing fim_reproducao.
REQ-033 nota_out SHALL be 0 whenever nota_valida=0.

Reset
REQ-034 Reset assertion SHALL force OCIOSO and set nota_out, nota_valida, num_eventos, cheio, saturou and fim_reproducao to 0, mid-operation included.
REQ-035 Reset SHALL NOT clear memory contents; num_eventos=0 SHALL define the memory as empty.

Configuration
REQ-036 With GRAVADOR_SEQUENCIA_LOOP_EN defined, the last event SHALL go to BUSCA at address 0, never pulse fim_reproducao, and stop only on para; without it, behaviour SHALL follow REQ-031.

Structure
REQ-037 Package gravador_pkg SHALL hold the state encoding, the NOTA_PAUSA=0 constant and the width helper functions.
REQ-038 The event store SHALL be sub-module ram_eventos_sync: PROFUNDIDADE x (NW+LARGURA_TEMPO), one write port, synchronous read.

Verification (PROFUNDIDADE=8, LARGURA_TEMPO=4)
REQ-039 The bench SHALL check: grava; key 2 held 3 ticks; key 5 held 2 ticks; para -> num_eventos=2, entries {3,3} and {6,2}.
REQ-040 The bench SHALL check: toca after REQ-039 -> nota_out=3 for 3 ticks, BUSCA gap, 6 for 2 ticks, then a fim_reproducao pulse and estado=0.
REQ-041 The bench SHALL check: key held 20 ticks -> stored duration 15 and saturou=1.
REQ-042 The bench SHALL check: 9 alternating notes of 1 tick each -> cheio=1 after the 8th write, estado=0 and num_eventos=8.
REQ-043 The bench SHALL check: toca with num_eventos=0 -> fim_reproducao pulse one cycle later; reset low during REPRODUZ -> all outputs 0 and estado=0.
REQ-044 The bench SHALL check: GRAVADOR_SEQUENCIA_LOOP_EN with 2 events -> the sequence repeats 3 times with no fim_reproducao; para -> estado=0.
